// File: rtl/mux16_scan_seq.sv
// mux16_scan_seq: handshaked word-to-serial sequencer driving mux16to1 data/select; define MUX16_SCAN_MSB_FIRST_EN for MSB-first order.
module mux16_scan_seq #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_out,
  output logic             ser_bit,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             done,
  output logic             busy
);
  typedef enum logic {IDLE, SCAN} state_t;
`ifdef MUX16_SCAN_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] START = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] FINAL = '0;
`else
  localparam logic [SEL_W-1:0] START = '0;
  localparam logic [SEL_W-1:0] FINAL = SEL_W'(WIDTH - 1);
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] mux_in_q, mux_in_d;
  logic [SEL_W-1:0] mux_sel_q, mux_sel_d, sel_next;
  logic ser_valid_q, ser_valid_d, done_q, done_d, busy_q, busy_d, word_ready_q, word_ready_d;
  logic accept, xfer, fin;
`ifdef MUX16_SCAN_MSB_FIRST_EN
  assign sel_next = mux_sel_q - SEL_W'(1);
`else
  assign sel_next = mux_sel_q + SEL_W'(1);
`endif
  always_comb begin
    accept       = state_q == IDLE && word_valid;
    xfer         = state_q == SCAN && ser_ready;
    fin          = xfer && mux_sel_q == FINAL;
    state_d      = accept ? SCAN : fin ? IDLE : state_q;
    mux_in_d     = accept ? word_in : mux_in_q;
    mux_sel_d    = (accept || fin) ? START : xfer ? sel_next : mux_sel_q;
    ser_valid_d  = state_d == SCAN;
    busy_d       = state_d == SCAN;
    word_ready_d = state_d == IDLE;
    done_d       = fin;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mux_in_q     <= '0;
      mux_sel_q    <= START;
      ser_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      word_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      mux_in_q     <= mux_in_d;
      mux_sel_q    <= mux_sel_d;
      ser_valid_q  <= ser_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      word_ready_q <= word_ready_d;
    end
  end
  assign mux_in     = mux_in_q;
  assign mux_sel    = mux_sel_q;
  assign ser_valid  = ser_valid_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign word_ready = word_ready_q;
  assign ser_bit    = mux_out;
  assign ser_last   = state_q == SCAN && mux_sel_q == FINAL;
endmodule

// File: tb/tb_mux16_scan_seq.sv
// tb_mux16_scan_seq: directed checks of mux16_scan_seq with a behavioural mux16to1 closing the loop.
module tb_mux16_scan_seq;
  logic clk = 0, rst = 1;
  logic [15:0] word_in = '0, mux_in;
  logic word_valid = 0, word_ready, mux_out, ser_bit, ser_valid, ser_ready = 1, ser_last, done, busy;
  logic [3:0] mux_sel;
  int checks = 0, errors = 0;

  mux16_scan_seq dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .mux_in(mux_in), .mux_sel(mux_sel), .mux_out(mux_out), .ser_bit(ser_bit), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .ser_last(ser_last), .done(done), .busy(busy)
  );

  assign mux_out = mux_in[mux_sel];
  always #5 clk = ~clk;

  // Stream position i maps to word bit i (LSB-first) or 15-i (MSB-first).
  function automatic logic exp_bit(input logic [15:0] w, input int i);
`ifdef MUX16_SCAN_MSB_FIRST_EN
    return w[15-i];
`else
    return w[i];
`endif
  endfunction

  function automatic logic [3:0] sel_of(input int i);
`ifdef MUX16_SCAN_MSB_FIRST_EN
    return 4'(15 - i);
`else
    return 4'(i);
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] w);
    word_in = w;
    word_valid = 1;
    tick();
    word_valid = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    tick(); tick();
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL reset_word_ready got %b want 1", word_ready); end
    checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL reset_ser_valid got %b want 0", ser_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    checks++; if (mux_in !== 16'h0) begin errors++; $display("FAIL reset_mux_in got %h want 0000", mux_in); end
    checks++; if (mux_sel !== sel_of(0)) begin errors++; $display("FAIL reset_mux_sel got %0d want %0d", mux_sel, sel_of(0)); end
    rst = 0;
    tick();
    checks++; if (ser_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_no_word got v%b b%b want 00", ser_valid, busy); end
  endtask

  task automatic test_stream;
    logic [15:0] w = 16'h3f0a;
    load(w);
    checks++; if (busy !== 1'b1 || ser_valid !== 1'b1 || word_ready !== 1'b0) begin errors++; $display("FAIL stream_start got b%b v%b r%b want 1 1 0", busy, ser_valid, word_ready); end
    checks++; if (mux_in !== w) begin errors++; $display("FAIL stream_mux_in got %h want %h", mux_in, w); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (ser_bit !== exp_bit(w, i)) begin errors++; $display("FAIL stream_bit%0d got %b want %b", i, ser_bit, exp_bit(w, i)); end
      checks++; if (ser_last !== (i == 15)) begin errors++; $display("FAIL stream_last%0d got %b want %b", i, ser_last, i == 15); end
      checks++; if (mux_sel !== sel_of(i)) begin errors++; $display("FAIL stream_sel%0d got %0d want %0d", i, mux_sel, sel_of(i)); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL stream_early_done%0d got %b want 0", i, done); end
      tick();
    end
    checks++; if (done !== 1'b1 || word_ready !== 1'b1) begin errors++; $display("FAIL stream_done got d%b r%b want 11", done, word_ready); end
    checks++; if (ser_valid !== 1'b0 || busy !== 1'b0 || ser_last !== 1'b0) begin errors++; $display("FAIL stream_idle got v%b b%b l%b want 000", ser_valid, busy, ser_last); end
    checks++; if (mux_sel !== sel_of(0)) begin errors++; $display("FAIL stream_sel_reload got %0d want %0d", mux_sel, sel_of(0)); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stream_done_pulse got %b want 0", done); end
  endtask

  task automatic test_stall;
    logic [15:0] w = 16'h3f0a;
    load(w);
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin
        ser_ready = 0;
        for (int k = 0; k < 3; k++) begin
          tick();
          checks++; if (mux_sel !== sel_of(2)) begin errors++; $display("FAIL stall_sel%0d got %0d want %0d", k, mux_sel, sel_of(2)); end
          checks++; if (ser_bit !== exp_bit(w, 2) || ser_valid !== 1'b1) begin errors++; $display("FAIL stall_out%0d got bit %b v %b want %b 1", k, ser_bit, ser_valid, exp_bit(w, 2)); end
        end
        ser_ready = 1;
      end
      checks++; if (ser_bit !== exp_bit(w, i) || mux_sel !== sel_of(i)) begin errors++; $display("FAIL stall_bit%0d got %b sel %0d want %b sel %0d", i, ser_bit, mux_sel, exp_bit(w, i), sel_of(i)); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [15:0] a = 16'hffff, b = 16'h0001;
    load(a);
    for (int i = 0; i < 16; i++) begin
      checks++; if (ser_bit !== 1'b1) begin errors++; $display("FAIL b2b_first_bit%0d got %b want 1", i, ser_bit); end
      tick();
    end
    checks++; if (done !== 1'b1 || word_ready !== 1'b1) begin errors++; $display("FAIL b2b_done got d%b r%b want 11", done, word_ready); end
    load(b);
    checks++; if (busy !== 1'b1 || ser_valid !== 1'b1 || mux_in !== b) begin errors++; $display("FAIL b2b_accept got b%b v%b in %h want 1 1 %h", busy, ser_valid, mux_in, b); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (ser_bit !== exp_bit(b, i) || ser_last !== (i == 15)) begin errors++; $display("FAIL b2b_second_bit%0d got %b last %b want %b %b", i, ser_bit, ser_last, exp_bit(b, i), i == 15); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_busy_reject;
    logic [15:0] w = 16'h3f0a;
    load(w);
    tick(); tick(); tick();
    word_in = 16'h1234;
    word_valid = 1;
    checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL reject_ready got %b want 0", word_ready); end
    tick();
    word_valid = 0;
    checks++; if (mux_in !== w) begin errors++; $display("FAIL reject_mux_in got %h want %h", mux_in, w); end
    for (int i = 4; i < 16; i++) begin
      checks++; if (ser_bit !== exp_bit(w, i) || mux_sel !== sel_of(i)) begin errors++; $display("FAIL reject_bit%0d got %b sel %0d want %b sel %0d", i, ser_bit, mux_sel, exp_bit(w, i), sel_of(i)); end
      tick();
    end
    checks++; if (done !== 1'b1 || mux_in !== w) begin errors++; $display("FAIL reject_done got d%b in %h want 1 %h", done, mux_in, w); end
    tick();
  endtask

  task automatic test_reset_mid;
    load(16'h3f0a);
    for (int i = 0; i < 5; i++) tick();
    checks++; if (mux_sel !== sel_of(5)) begin errors++; $display("FAIL midrst_pre_sel got %0d want %0d", mux_sel, sel_of(5)); end
    rst = 1;
    #1;
    checks++; if (ser_valid !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b1) begin errors++; $display("FAIL midrst_flags got v%b b%b r%b want 0 0 1", ser_valid, busy, word_ready); end
    checks++; if (mux_sel !== sel_of(0) || mux_in !== 16'h0) begin errors++; $display("FAIL midrst_regs got sel %0d in %h want %0d 0000", mux_sel, mux_in, sel_of(0)); end
    tick();
    rst = 0;
    for (int k = 0; k < 20; k++) begin
      checks++; if (done !== 1'b0 || ser_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_done%0d got d%b v%b want 00", k, done, ser_valid); end
      tick();
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
